// File: rtl/proc_result_checker.sv
// Self-check sequencer: resets the processor at a start PC, waits, samples dut_out against a table of expected values.
// Latency per entry: 1 LOAD + RST_CYCLES (new program only) + wait+1 WAIT + 1 CHECK cycle; done pulses 1 cycle after the last CHECK.
// No backpressure: start and cfg_we are accepted only in IDLE and dropped otherwise; PROC_CHECK_MASK_EN adds a per-entry compare mask.
module proc_result_checker #(
    parameter int DATA_W     = 32,
    parameter int PC_W       = 32,
    parameter int NUM_CHECKS = 16,
    parameter int WAIT_W     = 16,
    parameter int RST_CYCLES = 1
) (
    input  logic                          CLK,
    input  logic                          Reset_L,
    input  logic                          start,
    input  logic                          cfg_we,
    input  logic [$clog2(NUM_CHECKS)-1:0] cfg_idx,
    input  logic [PC_W-1:0]               cfg_pc,
    input  logic [WAIT_W-1:0]             cfg_wait,
    input  logic [DATA_W-1:0]             cfg_expect,
    input  logic                          cfg_newprog,
    input  logic                          cfg_last,
`ifdef PROC_CHECK_MASK_EN
    input  logic [DATA_W-1:0]             cfg_mask,
`endif
    input  logic [DATA_W-1:0]             dut_out,
    output logic                          dut_reset_L,
    output logic [PC_W-1:0]               dut_startPC,
    output logic                          busy,
    output logic                          done,
    output logic                          all_passed,
    output logic [7:0]                    pass_count,
    output logic [7:0]                    fail_count,
    output logic                          fail_valid,
    output logic [$clog2(NUM_CHECKS)-1:0] fail_idx
);

    localparam int IDX_W = $clog2(NUM_CHECKS);
    localparam int RC_W  = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_RST, S_WAIT, S_CHECK, S_FIN
    } state_t;

    state_t state, state_nxt;

    logic [PC_W-1:0]   tbl_pc      [NUM_CHECKS];
    logic [WAIT_W-1:0] tbl_wait    [NUM_CHECKS];
    logic [DATA_W-1:0] tbl_expect  [NUM_CHECKS];
    logic              tbl_newprog [NUM_CHECKS];
    logic              tbl_last    [NUM_CHECKS];
`ifdef PROC_CHECK_MASK_EN
    logic [DATA_W-1:0] tbl_mask    [NUM_CHECKS];
`endif

    logic [IDX_W-1:0]  idx;
    logic [RC_W-1:0]   rcnt;
    logic [WAIT_W-1:0] wcnt;
    logic              hit;
    logic [7:0]        pass_nxt;
    logic [7:0]        fail_nxt;
    logic              run_end;

    // Table storage is deliberately left out of reset so it survives a mid-run abort.
    always_ff @(posedge CLK) begin
        if (cfg_we && state == S_IDLE) begin
            tbl_pc[cfg_idx]      <= cfg_pc;
            tbl_wait[cfg_idx]    <= cfg_wait;
            tbl_expect[cfg_idx]  <= cfg_expect;
            tbl_newprog[cfg_idx] <= cfg_newprog;
            tbl_last[cfg_idx]    <= cfg_last;
`ifdef PROC_CHECK_MASK_EN
            tbl_mask[cfg_idx]    <= cfg_mask;
`endif
        end
    end

    always_comb begin
`ifdef PROC_CHECK_MASK_EN
        hit = ((dut_out ^ tbl_expect[idx]) & tbl_mask[idx]) == '0;
`else
        hit = (dut_out == tbl_expect[idx]);
`endif
        pass_nxt = pass_count;
        fail_nxt = fail_count;
        if (state == S_CHECK) begin
            if (hit && pass_count != 8'hFF)
                pass_nxt = pass_count + 8'd1;
            if (!hit && fail_count != 8'hFF)
                fail_nxt = fail_count + 8'd1;
        end
    end

    always_comb begin
        state_nxt = state;
        run_end   = 1'b0;
        case (state)
            S_IDLE:  if (start) state_nxt = S_LOAD;
            S_LOAD:  state_nxt = tbl_newprog[idx] ? S_RST : S_WAIT;
            S_RST:   if (rcnt == '0) state_nxt = S_WAIT;
            S_WAIT:  if (wcnt == '0) state_nxt = S_CHECK;
            S_CHECK: begin
                if (tbl_last[idx] || idx == IDX_W'(NUM_CHECKS - 1)) begin
                    state_nxt = S_FIN;
                    run_end   = 1'b1;
                end else begin
                    state_nxt = S_LOAD;
                end
            end
            S_FIN:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            dut_reset_L <= 1'b1;
            dut_startPC <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            all_passed  <= 1'b0;
            pass_count  <= '0;
            fail_count  <= '0;
            fail_valid  <= 1'b0;
            fail_idx    <= '0;
            idx         <= '0;
            rcnt        <= '0;
            wcnt        <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        pass_count <= '0;
                        fail_count <= '0;
                        fail_valid <= 1'b0;
                        fail_idx   <= '0;
                        all_passed <= 1'b0;
                        idx        <= '0;
                        busy       <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (tbl_newprog[idx]) begin
                        dut_startPC <= tbl_pc[idx];
                        dut_reset_L <= 1'b0;
                        rcnt        <= RC_W'(RST_CYCLES - 1);
                    end else begin
                        wcnt <= tbl_wait[idx];
                    end
                end
                S_RST: begin
                    if (rcnt == '0) begin
                        dut_reset_L <= 1'b1;
                        wcnt        <= tbl_wait[idx];
                    end else begin
                        rcnt <= rcnt - RC_W'(1);
                    end
                end
                S_WAIT: begin
                    if (wcnt != '0)
                        wcnt <= wcnt - WAIT_W'(1);
                end
                S_CHECK: begin
                    pass_count <= pass_nxt;
                    fail_count <= fail_nxt;
                    if (!hit && !fail_valid) begin
                        fail_idx   <= idx;
                        fail_valid <= 1'b1;
                    end
                    // Verdict uses the post-compare counts so it is valid alongside done.
                    if (run_end) begin
                        done       <= 1'b1;
                        busy       <= 1'b0;
                        all_passed <= (fail_nxt == 8'd0) && (pass_nxt != 8'd0);
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_proc_result_checker.sv
// Directed bench for proc_result_checker with a small processor model whose output settles a fixed number of cycles after reset release.
module tb_proc_result_checker;

    logic        CLK = 1'b0;
    logic        Reset_L = 1'b1;
    logic        start = 1'b0;
    logic        cfg_we = 1'b0;
    logic [3:0]  cfg_idx = '0;
    logic [31:0] cfg_pc = '0;
    logic [15:0] cfg_wait = '0;
    logic [31:0] cfg_expect = '0;
    logic        cfg_newprog = 1'b0;
    logic        cfg_last = 1'b0;
    logic [31:0] cfg_mask = '0;
    logic [31:0] dut_out;
    logic        dut_reset_L;
    logic [31:0] dut_startPC;
    logic        busy, done, all_passed, fail_valid;
    logic [7:0]  pass_count, fail_count;
    logic [3:0]  fail_idx;

    int checks = 0;
    int errors = 0;

    proc_result_checker #(.DATA_W(32), .PC_W(32), .NUM_CHECKS(16), .WAIT_W(16), .RST_CYCLES(1)) dut (
        .CLK(CLK), .Reset_L(Reset_L), .start(start), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
        .cfg_pc(cfg_pc), .cfg_wait(cfg_wait), .cfg_expect(cfg_expect),
        .cfg_newprog(cfg_newprog), .cfg_last(cfg_last),
`ifdef PROC_CHECK_MASK_EN
        .cfg_mask(cfg_mask),
`endif
        .dut_out(dut_out), .dut_reset_L(dut_reset_L), .dut_startPC(dut_startPC),
        .busy(busy), .done(done), .all_passed(all_passed), .pass_count(pass_count),
        .fail_count(fail_count), .fail_valid(fail_valid), .fail_idx(fail_idx)
    );

    always #5 CLK = ~CLK;

    // Processor model: c counts cycles since reset release; output depends on program and c.
    int          c = 0;
    int          mi;
    logic [31:0] mem_val [16];

    always @(posedge CLK) c <= dut_reset_L ? c + 1 : 0;

    always_comb begin
        dut_out = 32'h0;
        mi = (c >= 1) ? (c - 1) / 3 : 0;
        if (mi > 15) mi = 15;
        case (dut_startPC)
            32'h0000_0000: dut_out = (c >= 73) ? 32'd120 : 32'h0;
            32'h0000_0060: dut_out = (c >= 35) ? 32'd2 : 32'h0;
            32'h0000_00A0: dut_out = (c >= 69) ? 32'hfeedbeef + 32'((c - 69) / 3) : 32'h0;
            32'h0000_0100: dut_out = (c >= 1) ? mem_val[mi] : 32'h0;
            32'h0000_0200: dut_out = 32'hfeed4b4f;
            default:       dut_out = 32'h0;
        endcase
    end

    int          done_cnt;
    int          low_cycles;
    logic        timed_out;
    logic        busy_at_done;
    logic [31:0] pc_seq [$];

    task automatic write_entry(input int i, input logic [31:0] pc, input int w,
                               input logic [31:0] exp, input logic np, input logic last,
                               input logic [31:0] mask);
        @(negedge CLK);
        cfg_we = 1'b1; cfg_idx = 4'(i); cfg_pc = pc; cfg_wait = 16'(w);
        cfg_expect = exp; cfg_newprog = np; cfg_last = last; cfg_mask = mask;
        @(negedge CLK);
        cfg_we = 1'b0;
    endtask

    task automatic run(input logic inject);
        int after;
        done_cnt = 0; low_cycles = 0; timed_out = 1'b0; busy_at_done = 1'b1;
        pc_seq.delete();
        after = -1;
        @(negedge CLK); start = 1'b1;
        @(negedge CLK); start = 1'b0;
        pc_seq.push_back(dut_startPC);
        for (int k = 0; k < 5000; k++) begin
            if (inject && k == 1) begin
                cfg_we = 1'b1; cfg_idx = 4'd10; cfg_expect = 32'hdead0000;
                cfg_newprog = 1'b0; cfg_last = 1'b0; cfg_wait = 16'd0; cfg_pc = 32'h0;
            end
            if (inject && k == 2) begin
                cfg_idx = 4'd4; cfg_last = 1'b1; cfg_expect = 32'h1004;
            end
            if (inject && k == 3) cfg_we = 1'b0;
            if (!dut_reset_L) low_cycles++;
            if (dut_startPC != pc_seq[$]) pc_seq.push_back(dut_startPC);
            if (done) begin
                done_cnt++;
                if (after < 0) begin
                    after = k;
                    busy_at_done = busy;
                end
            end
            if (after >= 0 && k == after + 3) break;
            @(negedge CLK);
        end
        if (after < 0) timed_out = 1'b1;
    endtask

    task automatic test_reset;
        Reset_L = 1'b0;
        repeat (2) @(negedge CLK);
        checks++;
        if ({dut_reset_L, busy, done, all_passed, fail_valid} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_flags got %b want 10000", {dut_reset_L, busy, done, all_passed, fail_valid});
        end
        checks++;
        if ({pass_count, fail_count, fail_idx} !== 20'h0) begin
            errors++;
            $display("FAIL reset_counts got %h want 0", {pass_count, fail_count, fail_idx});
        end
        checks++;
        if (dut_startPC !== 32'h0) begin
            errors++;
            $display("FAIL reset_pc got %h want 0", dut_startPC);
        end
        Reset_L = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_single;
        write_entry(0, 32'h0, 72, 32'd120, 1'b1, 1'b1, 32'hffffffff);
        run(1'b0);
        checks++;
        if (timed_out || done_cnt != 1) begin
            errors++;
            $display("FAIL single_done got %0d pulses (timeout %0b) want 1", done_cnt, timed_out);
        end
        checks++;
        if (low_cycles != 1) begin
            errors++;
            $display("FAIL single_rst_low got %0d cycles want 1", low_cycles);
        end
        checks++;
        if ({pass_count, fail_count, all_passed, busy_at_done} !== {8'd1, 8'd0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL single_result got pass %0d fail %0d ap %0b busy %0b want 1 0 1 0",
                     pass_count, fail_count, all_passed, busy_at_done);
        end
    endtask

    task automatic test_multi_program;
        write_entry(0, 32'h0,  72, 32'd120,       1'b0, 1'b0, 32'hffffffff);
        write_entry(1, 32'h60, 34, 32'd2,         1'b1, 1'b0, 32'hffffffff);
        write_entry(2, 32'hA0, 68, 32'hfeedbeef,  1'b1, 1'b0, 32'hffffffff);
        for (int k = 1; k <= 11; k++)
            write_entry(2 + k, 32'h0, 0, 32'hfeedbeef + 32'(k), 1'b0, (k == 11), 32'hffffffff);
        run(1'b0);
        checks++;
        if (timed_out || pass_count !== 8'd14 || fail_count !== 8'd0) begin
            errors++;
            $display("FAIL multi_counts got pass %0d fail %0d (timeout %0b) want 14 0", pass_count, fail_count, timed_out);
        end
        checks++;
        if (pc_seq.size() != 3 || pc_seq[0] !== 32'h0 || pc_seq[1] !== 32'h60 || pc_seq[2] !== 32'hA0) begin
            errors++;
            $display("FAIL multi_pc_seq got %p want 0 60 a0", pc_seq);
        end
        checks++;
        if (low_cycles != 2) begin
            errors++;
            $display("FAIL multi_rst_low got %0d cycles want 2", low_cycles);
        end
    endtask

    task automatic test_mismatch;
        for (int k = 0; k < 16; k++) mem_val[k] = 32'h1000 + 32'(k);
        mem_val[3] = 32'h0000b4a1;
        for (int k = 0; k < 8; k++)
            write_entry(k, 32'h100, 0, (k == 3) ? 32'h0000b4a0 : (k == 5) ? 32'h5555 : 32'h1000 + 32'(k),
                        (k == 0), (k == 7), 32'hffffffff);
        run(1'b0);
        checks++;
        if (timed_out || fail_count !== 8'd2 || pass_count !== 8'd6) begin
            errors++;
            $display("FAIL mismatch_counts got pass %0d fail %0d want 6 2", pass_count, fail_count);
        end
        checks++;
        if ({fail_valid, fail_idx, all_passed} !== {1'b1, 4'd3, 1'b0}) begin
            errors++;
            $display("FAIL mismatch_capture got valid %0b idx %0d ap %0b want 1 3 0", fail_valid, fail_idx, all_passed);
        end
        mem_val[3] = 32'h1003;
    endtask

    task automatic test_table_bound;
        for (int k = 0; k < 16; k++)
            write_entry(k, 32'h100, 0, 32'h1000 + 32'(k), (k == 0), 1'b0, 32'hffffffff);
        run(1'b0);
        checks++;
        if (timed_out || done_cnt != 1 || pass_count !== 8'd16 || fail_count !== 8'd0) begin
            errors++;
            $display("FAIL bound_run got pass %0d fail %0d pulses %0d want 16 0 1", pass_count, fail_count, done_cnt);
        end
        checks++;
        if (all_passed !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL bound_status got ap %0b busy %0b want 1 0", all_passed, busy);
        end
    endtask

    task automatic test_ignored_writes;
        run(1'b1);
        checks++;
        if (timed_out || pass_count !== 8'd16 || fail_count !== 8'd0) begin
            errors++;
            $display("FAIL busy_write got pass %0d fail %0d want 16 0", pass_count, fail_count);
        end
    endtask

    task automatic test_reset_abort;
        int falls;
        int hi;
        logic prev;
        write_entry(0, 32'h100, 0,  32'h1000, 1'b1, 1'b0, 32'hffffffff);
        write_entry(1, 32'h60,  34, 32'd2,    1'b1, 1'b1, 32'hffffffff);
        @(negedge CLK); start = 1'b1;
        @(negedge CLK); start = 1'b0;
        falls = 0; hi = 0; prev = dut_reset_L;
        for (int k = 0; k < 500 && hi < 5; k++) begin
            if (prev && !dut_reset_L) falls++;
            if (falls == 2 && dut_reset_L) hi++;
            prev = dut_reset_L;
            @(negedge CLK);
        end
        checks++;
        if (hi < 5 || pass_count !== 8'd1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_setup got pass %0d busy %0b reached %0d want 1 1 5", pass_count, busy, hi);
        end
        #2 Reset_L = 1'b0;
        #1;
        checks++;
        if ({busy, dut_reset_L, fail_valid} !== 3'b010 || pass_count !== 8'd0 || fail_count !== 8'd0) begin
            errors++;
            $display("FAIL abort_wait got busy %0b rstL %0b pass %0d want 0 1 0", busy, dut_reset_L, pass_count);
        end
        @(negedge CLK); Reset_L = 1'b1;
        @(negedge CLK); start = 1'b1;
        @(negedge CLK); start = 1'b0;
        hi = 0;
        for (int k = 0; k < 20 && dut_reset_L; k++) @(negedge CLK);
        checks++;
        if (dut_reset_L !== 1'b0) begin
            errors++;
            $display("FAIL abort_rst_reach got rstL %0b want 0", dut_reset_L);
        end
        #2 Reset_L = 1'b0;
        #1;
        checks++;
        if (dut_reset_L !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_rst got rstL %0b busy %0b want 1 0", dut_reset_L, busy);
        end
        @(negedge CLK); Reset_L = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_mask;
        write_entry(0, 32'h200, 3, 32'hfeed0000, 1'b1, 1'b1, 32'hffff0000);
        run(1'b0);
`ifdef PROC_CHECK_MASK_EN
        checks++;
        if (timed_out || pass_count !== 8'd1 || fail_count !== 8'd0 || all_passed !== 1'b1) begin
            errors++;
            $display("FAIL mask_compare got pass %0d fail %0d want 1 0", pass_count, fail_count);
        end
`else
        checks++;
        if (timed_out || pass_count !== 8'd0 || fail_count !== 8'd1 || fail_idx !== 4'd0 || all_passed !== 1'b0) begin
            errors++;
            $display("FAIL mask_compare got pass %0d fail %0d want 0 1", pass_count, fail_count);
        end
`endif
    endtask

    initial begin
        for (int k = 0; k < 16; k++) mem_val[k] = 32'h1000 + 32'(k);
        test_reset;
        test_single;
        test_multi_program;
        test_mismatch;
        test_table_bound;
        test_ignored_writes;
        test_reset_abort;
        test_mask;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/proc_result_checker.md
Name: proc_result_checker

Overview:
- Synthesizable on-chip self-check sequencer for the pipelined processor.
- Holds the DUT processor in reset, drives its start PC, releases it, waits a programmed number of cycles, then samples the processor's data-memory output and compares it to an expected value.
- Steps through a loadable table of check entries and can cover multiple programs in one run.
- Accumulates pass/fail counts and reports the first failing entry, replacing hand-sequenced bench timing with a parametrised hardware block.

Parameters:
- DATA_W, 32, width of the DUT data output and of expected values
- PC_W, 32, width of the start PC driven to the DUT
- NUM_CHECKS, 16, number of check-table entries (power of two)
- WAIT_W, 16, width of the per-entry wait counter
- RST_CYCLES, 1, number of cycles dut_reset_L is held low per program start (≥1)

Ports:
- CLK  in  1  system clock
- Reset_L  in  1  asynchronous active-low reset
- start  in  1  pulse; begins a run at entry 0 when idle
- cfg_we  in  1  check-table write strobe
- cfg_idx  in  log2(NUM_CHECKS)  table entry index
- cfg_pc  in  PC_W  start PC for a new-program entry
- cfg_wait  in  WAIT_W  cycles to wait before sampling
- cfg_expect  in  DATA_W  expected DUT output
- cfg_newprog  in  1  entry restarts the DUT with cfg_pc
- cfg_last  in  1  entry ends the run
- dut_out  in  DATA_W  DUT data-memory output (dMemOut)
- dut_reset_L  out  1  active-low reset to the DUT
- dut_startPC  out  PC_W  start PC to the DUT
- busy  out  1  run in progress
- done  out  1  one-cycle pulse at run end
- all_passed  out  1  fail_count==0 and pass_count>0, valid after done
- pass_count  out  8  entries matched
- fail_count  out  8  entries mismatched
- fail_valid  out  1  at least one failure recorded
- fail_idx  out  log2(NUM_CHECKS)  first failing entry

Behaviour:
- One clock domain. Reset is asynchronous and active-low on Reset_L; all flops clear on assertion.
- Reset values:
  - dut_reset_L=1, dut_startPC=0.
  - busy=0, done=0, all_passed=0.
  - counts=0, fail_valid=0, fail_idx=0.
  - state=IDLE.
  - Check-table contents are not reset.
- Table writes: registered on cfg_we in IDLE only. cfg_we while busy is ignored.
- States:
  - IDLE: on start, clear counts, fail_valid and fail_idx; set idx=0; busy=1; then go to LOAD.
  - LOAD: read entry[idx].
    - If newprog: dut_startPC<=pc, dut_reset_L<=0, rcnt<=RST_CYCLES-1, go to RST.
    - Else: wcnt<=wait, go to WAIT.
  - RST: dut_reset_L stays low. When rcnt==0: dut_reset_L<=1, wcnt<=wait, go to WAIT. Otherwise decrement rcnt.
  - WAIT: decrement wcnt. When wcnt==0, go to CHECK. wait=0 therefore samples on the cycle after release or after LOAD.
  - CHECK: compare dut_out to expect.
    - Match: pass_count++.
    - Mismatch: fail_count++; if !fail_valid, latch fail_idx=idx and set fail_valid=1.
    - If last, or idx==NUM_CHECKS-1: go to FIN.
    - Else idx++, go to LOAD.
  - FIN: done=1 for one cycle, busy=0, all_passed updated, go to IDLE. Counts hold until the next start.
- dut_startPC holds its value between programs. Entries that are not newprog continue sampling the running DUT without a restart.
- Counts saturate at 255.
- start while busy is ignored.
- A start arriving in the same cycle as FIN is ignored.
- Reset_L asserted mid-run aborts immediately to IDLE with reset values. dut_reset_L returns to 1.

Optional Feature:
- Macro: PROC_CHECK_MASK_EN.
- Defined:
  - Each entry gains a DATA_W mask, written through an extra cfg_mask input port.
  - Compare becomes (dut_out & mask) == (expect & mask).
  - A mask of 0 counts as a pass.
- Undefined: no cfg_mask port, no mask storage; full-width equality compare.

Test Plan:
- Single-program run.
  - Stimulus: entry0 {newprog, pc=0x0, wait=72, expect=120, last}; dut_out=120 at sample.
  - Required: pass=1, fail=0, all_passed=1, done pulses once, dut_reset_L low exactly RST_CYCLES cycles.
- Multi-program run.
  - Stimulus: entries {pc=0x0, wait=72, exp=120}, {newprog, pc=0x60, wait=34, exp=2}, {newprog, pc=0xA0, wait=68, exp=0xfeedbeef}, then 11 non-newprog entries with wait=0 and the matching expected values; DUT model supplies those values.
  - Required: pass=14, fail=0, dut_startPC sequence 0x0, 0x60, 0xA0.
- Mismatch capture.
  - Stimulus: entry 3 expects 0x0000b4a0, DUT supplies 0x0000b4a1; entry 5 also mismatches.
  - Required: fail=2, fail_idx=3, fail_valid=1, all_passed=0.
- Table bound.
  - Stimulus: all 16 entries with no last flag.
  - Required: run stops after entry 15 with 16 compares.
- Reset and ignored writes.
  - Stimulus: Reset_L low during WAIT of entry 1.
  - Required: busy=0, counts=0, dut_reset_L=1 asynchronously.
  - Stimulus: cfg_we while busy.
  - Required: table unchanged.
- Mask (PROC_CHECK_MASK_EN).
  - Stimulus: mask=0xFFFF0000, expect=0xfeed0000, dut_out=0xfeed4b4f.
  - Required: pass. Without the macro the same stimulus fails.
